pipeline_ctrl_unit: RTL and testbench
=====================================

// Module: pipeline_ctrl_unit
// PURPOSE
//  Stall/flush sequencer for the 5-stage RISC-V pipeline; companion to the forwarding unit.
//  - Resolves hazards forwarding cannot fix: load-use, taken branch/jump, multi-cycle MDU op
//    (mul/div), data-memory wait states.
//  - Drives per-stage stall/flush strobes; keeps a 3-state FSM, MDU watchdog, perf counters.
// PARAMETERS
//  MDU_TIMEOUT  64  max cycles in MDU_BUSY before abort (>=2)
//  CNT_W        32  width of perf counters (wrap modulo 2^CNT_W)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      reset, synchronous, active-high
//  Rs1_D        in   5      source reg 1 of instr in Decode
//  Rs2_D        in   5      source reg 2 of instr in Decode
//  RD_E         in   5      dest reg of instr in Execute
//  LoadE        in   1      instr in Execute is a load
//  PCSrcE       in   1      branch/jump taken, resolved in Execute
//  MduStartE    in   1      multi-cycle MDU op in Execute (held while E stalled)
//  MduDone      in   1      MDU result valid this cycle
//  MemReqM      in   1      load/store in Memory stage
//  MemReady     in   1      data memory completes access this cycle
//  StallF       out  1      hold PC
//  StallD       out  1      hold IF/ID
//  StallE       out  1      hold ID/EX
//  StallM       out  1      hold EX/MEM
//  FlushD       out  1      clear IF/ID
//  FlushE       out  1      clear ID/EX (bubble)
//  FlushM       out  1      clear EX/MEM (bubble)
//  FlushW       out  1      clear MEM/WB (bubble)
//  MduAbort     out  1      1-cycle pulse: watchdog expired, MDU must cancel
//  MduErr       out  1      sticky: any watchdog expiry since reset
//  StallCnt     out  CNT_W  cycles with StallF=1
//  FlushCnt     out  CNT_W  cycles with PCSrcE-driven flush
// BEHAVIOUR
//  - Strobes combinational from state+inputs, forced 0 while rst=1; MduErr, MduAbort, counters,
//    FSM registered; on rst: state RUN, wdog=0, MduErr=0, MduAbort=0, counters=0.
//  - States: RUN, MEM_WAIT, MDU_BUSY. Priority within a cycle: mem > MDU > branch > load-use.
//  - Mem wait (MemReqM & !MemReady, any state): StallF/D/E/M=1, FlushW=1; from RUN -> MEM_WAIT;
//    MEM_WAIT holds while !MemReady; MemReady -> RUN (no stall that cycle); E re-evaluated after.
//  - MDU (RUN, MduStartE & !MduDone): StallF/D/E=1, FlushM=1; -> MDU_BUSY, wdog=0.
//    MDU_BUSY: same strobes, wdog++; MduDone -> strobes 0, -> RUN.
//    wdog==MDU_TIMEOUT-1 & !MduDone -> MduAbort=1 next cycle, MduErr=1, -> RUN.
//    MduStartE & MduDone in RUN: single-cycle, no stall.
//  - Branch (RUN, PCSrcE): FlushD=1, FlushE=1, no stalls; overrides load-use same cycle.
//  - Load-use (RUN, LoadE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D)): StallF=1, StallD=1,
//    FlushE=1; single-cycle, no state change.
//  - Never StallX and FlushX on same stage same cycle.
//  - StallCnt += StallF each cycle; FlushCnt += (PCSrcE & no higher-priority stall); wrap silently.
//  - rst mid-MDU_BUSY/MEM_WAIT: next cycle RUN, all cleared, no MduAbort.
// STRUCTURE
//  - pipeline_ctrl_pkg: state enum ctrl_state_t {RUN, MEM_WAIT, MDU_BUSY}; REG_W=5; X0 const.
//  - Sub-module perf_cnt (CNT_W, inc, clk, rst -> count), two instances.
//  - Combinational strobe decode in one always_comb; FSM + watchdog in one always_ff.
// TESTING
//  - LoadE=1, RD_E=5, Rs1_D=5 -> StallF=StallD=FlushE=1 one cycle; RD_E=0 -> no stall.
//  - LoadE=1 RD_E=5 Rs2_D=5, PCSrcE=1 -> FlushD=FlushE=1, StallF=0, FlushCnt+1.
//  - MduStartE=1, MduDone after 4 cycles -> StallF/D/E, FlushM high 4 cycles, 0 on done cycle.
//  - MDU_TIMEOUT=8, MduDone never -> after 8 stall cycles MduAbort pulses 1 cycle, MduErr=1, RUN.
//  - MemReqM=1, MemReady low 3 cycles, MduStartE=1 -> 3 mem stalls (StallM, FlushW), then MDU.
//  - rst=1 during MDU_BUSY -> next cycle all strobes 0, counters 0, MduErr=0, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush sequencer.
//   - ctrl_state_t : sequencer FSM states
//   - strobe_t     : per-stage stall/flush strobe bundle plus the canned patterns
//                    for each hazard class
//   - load_use_hazard() : Decode-vs-Execute register dependency on a load
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] X0 = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MDU_BUSY = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_e;
      logic flush_m;
      logic flush_w;
   } strobe_t;

   // Bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
   localparam strobe_t STRB_NONE = 8'b0000_0000;
   localparam strobe_t STRB_MEM  = 8'b1111_0001;
   localparam strobe_t STRB_MDU  = 8'b1110_0010;
   localparam strobe_t STRB_BR   = 8'b0000_1100;
   localparam strobe_t STRB_LU   = 8'b1100_0100;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   function automatic logic load_use_hazard(input logic             load_e,
                                            input logic [REG_W-1:0] rd_e,
                                            input logic [REG_W-1:0] rs1_d,
                                            input logic [REG_W-1:0] rs2_d);
      return load_e && (rd_e != X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// pipeline_ctrl_unit_if
//   Bundle between the pipeline datapath and the stall/flush sequencer.
//   Names are from the sequencer's point of view: i_* flow into it, o_* out of it.
//   modport master : pipeline side (drives hazard inputs, consumes strobes)
//   modport slave  : sequencer side
//   Inputs : i_rs1_d, i_rs2_d, i_rd_e, i_load_e, i_pcsrc_e, i_mdu_start_e,
//            i_mdu_done, i_mem_req_m, i_mem_ready
//   Outputs: o_stall_{f,d,e,m}, o_flush_{d,e,m,w}, o_mdu_abort, o_mdu_err,
//            o_stall_cnt, o_flush_cnt
interface pipeline_ctrl_unit_if #(
   parameter int CNT_W = 32
);
   import pipeline_ctrl_pkg::*;

   logic [REG_W-1:0] i_rs1_d;
   logic [REG_W-1:0] i_rs2_d;
   logic [REG_W-1:0] i_rd_e;
   logic             i_load_e;
   logic             i_pcsrc_e;
   logic             i_mdu_start_e;
   logic             i_mdu_done;
   logic             i_mem_req_m;
   logic             i_mem_ready;

   logic             o_stall_f;
   logic             o_stall_d;
   logic             o_stall_e;
   logic             o_stall_m;
   logic             o_flush_d;
   logic             o_flush_e;
   logic             o_flush_m;
   logic             o_flush_w;
   logic             o_mdu_abort;
   logic             o_mdu_err;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_rs1_d, i_rs2_d, i_rd_e, i_load_e, i_pcsrc_e,
             i_mdu_start_e, i_mdu_done, i_mem_req_m, i_mem_ready,
      input  o_stall_f, o_stall_d, o_stall_e, o_stall_m,
             o_flush_d, o_flush_e, o_flush_m, o_flush_w,
             o_mdu_abort, o_mdu_err, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_rs1_d, i_rs2_d, i_rd_e, i_load_e, i_pcsrc_e,
             i_mdu_start_e, i_mdu_done, i_mem_req_m, i_mem_ready,
      output o_stall_f, o_stall_d, o_stall_e, o_stall_m,
             o_flush_d, o_flush_e, o_flush_m, o_flush_w,
             o_mdu_abort, o_mdu_err, o_stall_cnt, o_flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_unit_perf_cnt.sv
// perf_cnt
//   Free-running event counter, wraps modulo 2^CNT_W.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears the count
//   i_inc   : count this cycle
//   o_count : current count
module perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit
//   Stall/flush sequencer for the 5-stage pipeline. Handles the hazards the
//   forwarding unit cannot: data-memory wait states, multi-cycle MDU ops,
//   taken branches/jumps and load-use dependencies.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : pipeline_ctrl_unit_if.slave (hazard inputs, stage strobes,
//           MDU watchdog abort/error, perf counters)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal issue; hazards resolved by priority mem > MDU > branch > load-use
//   MEM_WAIT | data memory stalled; whole front end held, bubble into WB
//   MDU_BUSY | multi-cycle MDU op held in Execute; watchdog counting
module pipeline_ctrl_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   pipeline_ctrl_unit_if.slave  bus
);

   localparam int WDOG_W = $clog2(MDU_TIMEOUT);

   ctrl_state_t       r_state;
   ctrl_state_t       w_state_nxt;
   logic [WDOG_W-1:0] r_wdog;
   logic              r_mdu_abort;
   logic              r_mdu_err;

   strobe_t           w_strb;
   logic              w_mem_stall;
   logic              w_load_use;
   logic              w_mdu_timeout;
   logic              w_br_flush;
   logic [CNT_W-1:0]  w_stall_cnt;
   logic [CNT_W-1:0]  w_flush_cnt;

   always_comb begin
      w_state_nxt   = r_state;
      w_strb        = STRB_NONE;
      w_mdu_timeout = 1'b0;
      w_br_flush    = 1'b0;
      w_mem_stall   = bus.i_mem_req_m & ~bus.i_mem_ready;
      w_load_use    = load_use_hazard(bus.i_load_e, bus.i_rd_e, bus.i_rs1_d, bus.i_rs2_d);

      unique case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               w_strb      = STRB_MEM;
               w_state_nxt = MEM_WAIT;
            end else if (bus.i_mdu_start_e && !bus.i_mdu_done) begin
               w_strb      = STRB_MDU;
               w_state_nxt = MDU_BUSY;
            end else if (bus.i_pcsrc_e) begin
               w_strb      = STRB_BR;
               w_br_flush  = 1'b1;
            end else if (w_load_use) begin
               w_strb      = STRB_LU;
            end
         end

         // The completing cycle issues nothing; Execute is re-evaluated from RUN.
         MEM_WAIT: begin
            if (!bus.i_mem_ready) begin
               w_strb      = STRB_MEM;
            end else begin
               w_state_nxt = RUN;
            end
         end

         // A memory stall still wins on the strobes, but the MDU keeps
         // running underneath, so completion and the watchdog track it regardless.
         MDU_BUSY: begin
            if (w_mem_stall) begin
               w_strb = STRB_MEM;
            end else if (!bus.i_mdu_done) begin
               w_strb = STRB_MDU;
            end

            if (bus.i_mdu_done) begin
               w_state_nxt = RUN;
            end else if (r_wdog == WDOG_W'(MDU_TIMEOUT - 1)) begin
               w_mdu_timeout = 1'b1;
               w_state_nxt   = RUN;
            end
         end

         default: begin
            w_state_nxt = RUN;
         end
      endcase

      if (i_rst) begin
         w_strb     = STRB_NONE;
         w_br_flush = 1'b0;
      end
   end

   // Watchdog restarts at 0 on entry to MDU_BUSY and counts each busy cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= RUN;
         r_wdog      <= '0;
         r_mdu_abort <= 1'b0;
         r_mdu_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mdu_abort <= w_mdu_timeout;
         if (w_mdu_timeout) begin
            r_mdu_err <= 1'b1;
         end
         if (r_state == MDU_BUSY) begin
            r_wdog <= r_wdog + WDOG_W'(1);
         end else begin
            r_wdog <= '0;
         end
      end
   end

   perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_strb.stall_f),
      .o_count (w_stall_cnt)
   );

   perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_br_flush),
      .o_count (w_flush_cnt)
   );

   assign bus.o_stall_f   = w_strb.stall_f;
   assign bus.o_stall_d   = w_strb.stall_d;
   assign bus.o_stall_e   = w_strb.stall_e;
   assign bus.o_stall_m   = w_strb.stall_m;
   assign bus.o_flush_d   = w_strb.flush_d;
   assign bus.o_flush_e   = w_strb.flush_e;
   assign bus.o_flush_m   = w_strb.flush_m;
   assign bus.o_flush_w   = w_strb.flush_w;
   assign bus.o_mdu_abort = r_mdu_abort;
   assign bus.o_mdu_err   = r_mdu_err;
   assign bus.o_stall_cnt = w_stall_cnt;
   assign bus.o_flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit
//   Directed bench for pipeline_ctrl_unit with MDU_TIMEOUT=8.
//   Strobes are compared as one 8-bit vector
//   {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}.
module tb_pipeline_ctrl_unit;

   localparam int MDU_TIMEOUT = 8;
   localparam int CNT_W       = 32;

   localparam logic [7:0] S_NONE = 8'b0000_0000;
   localparam logic [7:0] S_MEM  = 8'b1111_0001;
   localparam logic [7:0] S_MDU  = 8'b1110_0010;
   localparam logic [7:0] S_BR   = 8'b0000_1100;
   localparam logic [7:0] S_LU   = 8'b1100_0100;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   exp_stall;
   int   exp_flush;

   pipeline_ctrl_unit_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl_unit #(
      .MDU_TIMEOUT (MDU_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   logic [7:0] strobes;
   assign strobes = {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m,
                     bus.o_flush_d, bus.o_flush_e, bus.o_flush_m, bus.o_flush_w};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the combinational strobes mid-cycle, books the expected counter
   // increments, then advances to just after the next rising edge.
   task automatic cyc(input string tag, input logic [7:0] exp, input bit br);
      @(negedge clk);
      check(tag, {56'd0, strobes}, {56'd0, exp});
      if (exp[7]) exp_stall++;
      if (br) exp_flush++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_rs1_d       = '0;
      bus.i_rs2_d       = '0;
      bus.i_rd_e        = '0;
      bus.i_load_e      = 1'b0;
      bus.i_pcsrc_e     = 1'b0;
      bus.i_mdu_start_e = 1'b0;
      bus.i_mdu_done    = 1'b0;
      bus.i_mem_req_m   = 1'b0;
      bus.i_mem_ready   = 1'b0;
   endtask

   task automatic check_regs(input string tag, input bit abort, input bit err);
      check({tag, "_stall_cnt"}, {32'd0, bus.o_stall_cnt}, 64'(exp_stall));
      check({tag, "_flush_cnt"}, {32'd0, bus.o_flush_cnt}, 64'(exp_flush));
      check({tag, "_abort"}, {63'd0, bus.o_mdu_abort}, {63'd0, abort});
      check({tag, "_err"}, {63'd0, bus.o_mdu_err}, {63'd0, err});
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_stall = 0;
      exp_flush = 0;
      clear_inputs();

      // Reset with a load-use hazard present: strobes must stay low.
      rst            = 1'b1;
      bus.i_load_e   = 1'b1;
      bus.i_rd_e     = 5'd5;
      bus.i_rs1_d    = 5'd5;
      cyc("rst_strobes0", S_NONE, 0);
      cyc("rst_strobes1", S_NONE, 0);
      rst = 1'b0;
      check_regs("after_rst", 0, 0);

      // Load-use on rs1, then gone.
      cyc("lu_rs1", S_LU, 0);
      clear_inputs();
      cyc("lu_cleared", S_NONE, 0);

      // Load into x0 and non-matching registers never stall.
      bus.i_load_e = 1'b1;
      bus.i_rd_e   = 5'd0;
      bus.i_rs1_d  = 5'd0;
      cyc("lu_x0", S_NONE, 0);
      bus.i_rd_e   = 5'd5;
      bus.i_rs1_d  = 5'd6;
      bus.i_rs2_d  = 5'd7;
      cyc("lu_nomatch", S_NONE, 0);

      // Branch overrides a simultaneous load-use on rs2.
      bus.i_rs2_d   = 5'd5;
      bus.i_pcsrc_e = 1'b1;
      cyc("br_over_lu", S_BR, 1);
      clear_inputs();
      check_regs("after_br", 0, 0);

      // MDU op completing on the fifth cycle: four stall cycles, clean done cycle.
      bus.i_mdu_start_e = 1'b1;
      for (int i = 0; i < 4; i++) cyc("mdu_stall", S_MDU, 0);
      bus.i_mdu_done = 1'b1;
      cyc("mdu_done", S_NONE, 0);
      bus.i_mdu_start_e = 1'b0;
      bus.i_mdu_done    = 1'b0;
      cyc("mdu_idle", S_NONE, 0);

      // Start and done together in RUN: single-cycle op, no stall, stays in RUN.
      bus.i_mdu_start_e = 1'b1;
      bus.i_mdu_done    = 1'b1;
      cyc("mdu_1cyc", S_NONE, 0);
      clear_inputs();
      bus.i_pcsrc_e = 1'b1;
      cyc("mdu_1cyc_run", S_BR, 1);
      clear_inputs();
      check_regs("after_mdu", 0, 0);

      // Watchdog: entry cycle plus 8 cycles in MDU_BUSY (wdog 0..7), then abort.
      bus.i_mdu_start_e = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("to_abort_low", {63'd0, bus.o_mdu_abort}, 64'd0);
         cyc("to_stall", S_MDU, 0);
      end
      check_regs("to_fire", 1, 1);
      bus.i_mdu_start_e = 1'b0;
      cyc("to_run", S_NONE, 0);
      check_regs("to_after", 0, 1);

      // Memory wait for 3 cycles with an MDU op waiting in Execute.
      bus.i_mem_req_m   = 1'b1;
      bus.i_mem_ready   = 1'b0;
      bus.i_mdu_start_e = 1'b1;
      for (int i = 0; i < 3; i++) cyc("mem_stall", S_MEM, 0);
      bus.i_mem_ready = 1'b1;
      cyc("mem_ready", S_NONE, 0);
      bus.i_mem_req_m = 1'b0;
      bus.i_mem_ready = 1'b0;
      cyc("mem_then_mdu", S_MDU, 0);
      bus.i_mdu_done = 1'b1;
      cyc("mem_mdu_done", S_NONE, 0);
      clear_inputs();
      check_regs("after_mem", 0, 1);

      // Reset in the middle of MDU_BUSY.
      bus.i_mdu_start_e = 1'b1;
      cyc("rb_enter", S_MDU, 0);
      cyc("rb_busy", S_MDU, 0);
      rst = 1'b1;
      cyc("rb_rst", S_NONE, 0);
      rst = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      clear_inputs();
      check_regs("rb_cleared", 0, 0);
      bus.i_pcsrc_e = 1'b1;
      cyc("rb_run", S_BR, 1);
      clear_inputs();
      cyc("rb_idle", S_NONE, 0);
      check_regs("rb_final", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
